// File: rtl/bf16_dec_formatter.sv
// BF16 -> sign + DDD.DD BCD formatter, round half-up to 0.01, saturating at 999.99.
// Start/done level handshake so it chains directly behind the BF16 ALU units.
module bf16_dec_formatter #(
    parameter int INT_DIGITS  = 3,
    parameter int FRAC_DIGITS = 2,
    parameter int NBIN        = 17
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [15:0]                            bf16_in,
    input  logic                                   err_in,
    output logic                                   sign,
    output logic [4*(INT_DIGITS+FRAC_DIGITS)-1:0]  bcd,
    output logic                                   nan,
    output logic                                   ovf,
    output logic                                   done
);
    localparam int ND = INT_DIGITS + FRAC_DIGITS;
    localparam int BW = 4 * ND;
    localparam int CW = $clog2(NBIN);
    localparam logic [BW-1:0]   SAT  = {ND{4'h9}};
    localparam logic [NBIN-1:0] NMAX = NBIN'(10 ** ND - 1);

    typedef enum logic [1:0] {IDLE, DECODE, CONVERT, DONE} state_t;
    state_t state, state_nx;

    logic [15:0]     in_q;
    logic            err_q;
    logic [NBIN-1:0] bin_q;
    logic [BW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic            nz_q;

    logic [7:0]      e;
    logic [6:0]      m;
    logic [NBIN-1:0] p, n_dec;
    logic [7:0]      kk, rs;
    logic            is_nan, is_inf, is_zero, dec_ovf, dec_norm;
    logic [BW-1:0]   adj, acc_nx;

    // Scaled magnitude N = round(|value| * 100); value = {1,m} * 2^(e-134).
    always_comb begin
        e       = in_q[14:7];
        m       = in_q[6:0];
        p       = {9'd0, 1'b1, m} * NBIN'(100);
        n_dec   = '0;
        kk      = '0;
        rs      = '0;
        dec_ovf = 1'b0;
        is_nan  = err_q || (e == 8'hFF && m != 7'd0);
        is_inf  = (e == 8'hFF) && (m == 7'd0);
        is_zero = (e == 8'h00);
        if (e >= 8'd134) begin
            kk = e - 8'd134;
            if (kk >= 8'd3) dec_ovf = 1'b1;
            else            n_dec = p << kk[1:0];
        end else begin
            rs = 8'd134 - e;
            if (rs < 8'd16) n_dec = (p + (NBIN'(1) << (rs - 8'd1))) >> rs;
        end
        if (n_dec > NMAX) dec_ovf = 1'b1;
        dec_norm = !is_nan && !is_inf && !is_zero && !dec_ovf;
    end

    // Double-dabble step: bias nibbles >= 5, then shift the next binary bit in.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < ND; i++)
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        acc_nx = {adj[BW-2:0], bin_q[NBIN-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = DECODE;
            DECODE:  state_nx = dec_norm ? CONVERT : DONE;
            CONVERT: if (cnt_q == CW'(NBIN - 1)) state_nx = DONE;
            DONE:    if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign done = (state == DONE);

    // Visible outputs change only in DECODE (special paths) or on the last CONVERT step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q  <= '0;
            err_q <= 1'b0;
            bin_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            nz_q  <= 1'b0;
            sign  <= 1'b0;
            bcd   <= '0;
            nan   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    in_q  <= bf16_in;
                    err_q <= err_in;
                end
                DECODE: begin
                    if (is_nan) begin
                        nan <= 1'b1; sign <= 1'b0; bcd <= '0;  ovf <= 1'b0;
                    end else if (is_inf || dec_ovf) begin
                        nan <= 1'b0; sign <= in_q[15]; bcd <= SAT; ovf <= 1'b1;
                    end else if (is_zero) begin
                        nan <= 1'b0; sign <= 1'b0; bcd <= '0;  ovf <= 1'b0;
                    end else begin
                        bin_q <= n_dec;
                        acc_q <= '0;
                        cnt_q <= '0;
                        nz_q  <= (n_dec != '0);
                    end
                end
                CONVERT: begin
                    bin_q <= bin_q << 1;
                    acc_q <= acc_nx;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NBIN - 1)) begin
                        bcd  <= acc_nx;
                        sign <= in_q[15] & nz_q;
                        nan  <= 1'b0;
                        ovf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_dec_formatter.sv
// Randomized + directed bench for bf16_dec_formatter against a real-arithmetic reference.
module tb_bf16_dec_formatter;
    logic        clk = 0, rst_n = 0, start = 0, err_in = 0;
    logic [15:0] bf16_in = '0;
    logic        sign, nan, ovf, done;
    logic [19:0] bcd;
    int n_chk = 0, n_fail = 0;

    bf16_dec_formatter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bf16_in(bf16_in), .err_in(err_in),
        .sign(sign), .bcd(bcd), .nan(nan), .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: exact value*100 in double precision, round half-up, then decimal digits.
    function automatic void ref_fmt(input logic [15:0] v, input logic err,
                                    output logic s, output logic [19:0] b, output logic n,
                                    output logic o, output logic spec);
        int     e, m;
        real    x;
        longint q;
        e = int'(v[14:7]);
        m = int'(v[6:0]);
        s = 0; b = '0; n = 0; o = 0; spec = 1;
        if (err || (e == 255 && m != 0)) n = 1;
        else if (e == 255) begin o = 1; b = 20'h99999; s = v[15]; end
        else if (e != 0) begin
            x = real'(128 + m) * 100.0 * (2.0 ** (e - 134));
            x = $floor(x + 0.5);
            if (x >= 100000.0) begin o = 1; b = 20'h99999; s = v[15]; end
            else begin
                spec = 0;
                q = longint'(x);
                s = v[15] && (q != 0);
                for (int i = 0; i < 5; i++) begin
                    b[4*i +: 4] = 4'(q % 10);
                    q = q / 10;
                end
            end
        end
    endfunction

    task automatic run(input logic [15:0] v, input logic err, input string tag);
        logic es, en, eo, esp, ps, pn, po;
        logic [19:0] eb, pb;
        int lat = 0;
        bit moved = 0, bad_nib = 0;
        ref_fmt(v, err, es, eb, en, eo, esp);
        @(negedge clk);
        bf16_in = v; err_in = err; start = 1;
        ps = sign; pb = bcd; pn = nan; po = ovf;
        while (lat < 40) begin
            @(posedge clk); #1; lat++;
            if (lat == 1) begin bf16_in = 16'($urandom); err_in = 1'($urandom); end
            if (done) break;
            if ({sign, bcd, nan, ovf} !== {ps, pb, pn, po}) moved = 1;
        end
        check({tag, ":latency"}, 32'(lat), esp ? 32'd2 : 32'd19);
        check({tag, ":sign"}, 32'(sign), 32'(es));
        check({tag, ":bcd"},  32'(bcd),  32'(eb));
        check({tag, ":nan"},  32'(nan),  32'(en));
        check({tag, ":ovf"},  32'(ovf),  32'(eo));
        for (int i = 0; i < 5; i++) if (bcd[4*i +: 4] > 4'd9) bad_nib = 1;
        check({tag, ":nibble"}, 32'(bad_nib), 32'd0);
        check({tag, ":hold"}, 32'(moved), 32'd0);
        repeat (2) @(posedge clk);
        #1 check({tag, ":done_held"}, 32'(done), 32'd1);
        @(negedge clk) start = 0;
        @(posedge clk); #1 check({tag, ":done_fall"}, 32'(done), 32'd0);
        @(posedge clk); #1 check({tag, ":single"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] v;
        #1 check("reset", 32'({sign, bcd, nan, ovf, done}), 32'd0);
        @(negedge clk) rst_n = 1;

        run(16'h42B4, 0, "p90");    check("p90_const", 32'(bcd), 32'h09000);
        run(16'hC2B4, 0, "n90");    check("n90_sign", 32'(sign), 32'd1);
        run(16'h3FC0, 0, "p1_5");   check("p1_5_const", 32'(bcd), 32'h00150);
        run(16'h3DCD, 0, "p0_10");  check("p0_10_const", 32'(bcd), 32'h00010);
        run(16'h8000, 0, "negz");
        run(16'h447A, 0, "p1000");  check("p1000_const", 32'({ovf, bcd}), 32'h199999);
        run(16'h4479, 0, "p996");
        run(16'h7F80, 0, "pinf");
        run(16'hFF80, 0, "ninf");
        run(16'hFFC0, 0, "qnan");   check("qnan_const", 32'({nan, bcd}), 32'h100000);
        run(16'h4000, 1, "err");
        run(16'h0080, 0, "tiny");
        run(16'h8080, 0, "ntiny");
        run(16'h3C24, 0, "half");

        // Asynchronous reset in the middle of CONVERT after a nonzero result.
        run(16'hC2B4, 0, "pre_rst");
        @(negedge clk);
        bf16_in = 16'h42B4; start = 1;
        repeat (10) @(posedge clk);
        #1 rst_n = 0; start = 0;
        #1 check("rst_mid", 32'({sign, bcd, nan, ovf, done}), 32'd0);
        @(negedge clk) rst_n = 1;
        run(16'h42B4, 0, "after_rst");

        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 3) != 0)
                v = {1'($urandom), 8'($urandom_range(105, 142)), 7'($urandom)};
            else
                v = 16'($urandom);
            run(v, ($urandom_range(0, 15) == 0), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bf16_dec_formatter.md
Name: bf16_dec_formatter

Overview:
- Downstream stage of the calculator's BF16-result ALU units (arcsin, arccos, and similar).
- Converts a 16-bit BF16 result into sign + 5 BCD digits (DDD.DD), rounded half-up to 0.01, with NaN/overflow flags.
- Output feeds the seven-segment display driver.
- Uses the same start/done level handshake as the ALU units, so it can be chained directly on their done/result/error.

Parameters:
- INT_DIGITS, 3, integer BCD digits (fixed; sets saturation bound 999.99)
- FRAC_DIGITS, 2, fractional BCD digits (fixed; scale factor 100)
- NBIN, 17, width of scaled binary magnitude (covers 0..99999)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level request; sampled only in IDLE
- bf16_in  input  `INPUTOUTBIT (16)  BF16 value to format
- err_in  input  1  upstream error flag; forces NaN display
- sign  output  1  1 = negative
- bcd  output  20  {hundreds, tens, units, tenths, hundredths}, 4 bits each
- nan  output  1  value is NaN or err_in was set
- ovf  output  1  rounded |value| >= 1000.00 (inf included); bcd saturated to 999.99
- done  output  1  result valid; held until start drops

Behaviour:
- Reset (rst_n low, async): state=IDLE; sign, bcd, nan, ovf, done all 0. Reset mid-conversion aborts with no output update.
- IDLE:
  - done=0.
  - On start=1: latch bf16_in and err_in, go to DECODE.
- DECODE (1 cycle): e=exp[14:7], m=mant[6:0].
  - err_in=1, or e=FF with m!=0: nan=1, sign=0, bcd=0, ovf=0 -> DONE.
  - e=FF with m=0 (inf): ovf=1, bcd=999.99, sign=bit15 -> DONE.
  - e=0 (zero/subnormal): bcd=0, sign=0, nan=0, ovf=0 -> DONE.
  - Otherwise: P=({1,m}*100) (15 bits, max 25500); k=e-134.
    - k>=0: N=P<<k. If k>=3 or N>99999: ovf=1, bcd=999.99 -> DONE.
    - k<0: N=(P+2^(-k-1))>>(-k); N=0 when -k>=16.
    - N in 100000 range after rounding: ovf path.
    - Else load N into shift reg, clear BCD accum, cnt=0 -> CONVERT.
- CONVERT (NBIN=17 cycles): double-dabble, one bit per cycle.
  - Add 3 to every BCD nibble >=5, then shift left {bcd,bin} by 1.
  - cnt increments each cycle; after cnt==16 register bcd, sign=bit15 (0 if N==0), nan=0, ovf=0 -> DONE.
- DONE: done=1. When start=0, go to IDLE; done clears in that IDLE cycle.
- Latency from the edge sampling start to done=1:
  - Normal path: 19 edges.
  - Special/ovf path: 2 edges.
- sign/bcd/nan/ovf hold until the next conversion's final update; they never glitch during CONVERT.
- start held high continuously: exactly one conversion; done stays 1 until start falls.
- bf16_in changes after sampling: ignored.

Test Plan:
- bf16_in=0x42B4 (90.0), start held -> after 19 edges: done=1, sign=0, bcd=0_9_0_0_0, nan=0, ovf=0; done falls one cycle after start=0.
- bf16_in=0xC2B4 (-90.0) -> sign=1, bcd=0_9_0_0_0. Then 0x3FC0 (1.5) -> sign=0, bcd=0_0_1_5_0.
- bf16_in=0x3DCD (~0.10010) -> bcd=0_0_0_1_0 (rounding). bf16_in=0x8000 (-0) -> sign=0, bcd=0, 2-edge latency.
- bf16_in=0x447A (1000.0) -> ovf=1, bcd=9_9_9_9_9. 0x7F80 (+inf) -> ovf=1. 0xFFC0 -> nan=1, bcd=0. Any value with err_in=1 -> nan=1, all on 2-edge latency.
- Assert rst_n low at CONVERT cycle 8 -> all outputs 0 immediately. Release, start with 0x42B4 -> correct 090.00 after 19 edges.
- Sweep all finite BF16 encodings against a golden round-half-up model.
  - Check bcd nibbles are each <=9, done pulses once per start.
